// File: rtl/tx_sync_insert_stage_pkg.sv
// Shared constants for the TX sync-insert stage and its receive-side counterpart.
// The blocklock field positions must match on both ends of the link.
package tx_sync_insert_stage_pkg;
  localparam int unsigned WR_WIDTH_DEFAULT    = 48;
  localparam int unsigned SYNC_PERIOD_DEFAULT = 1024;
  localparam int unsigned SYNC_BIT            = WR_WIDTH_DEFAULT - 1;
  localparam int unsigned BLOCKLOCK_LSB       = 0;
  localparam int unsigned BLOCKLOCK_MSB       = 3;
  localparam int unsigned BLOCKLOCK_W         = BLOCKLOCK_MSB - BLOCKLOCK_LSB + 1;

  typedef enum logic [1:0] {
    PUSH_NONE,
    PUSH_SYNC,
    PUSH_DATA
  } push_kind_e;
endpackage

// File: rtl/tx_sync_insert_stage_scheduler.sv
// Decides when a sync word is due: periodic data-word count or a change in local block lock.
module tx_sync_scheduler
  import tx_sync_insert_stage_pkg::*;
#(
  parameter int unsigned SYNC_PERIOD = SYNC_PERIOD_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_enable,
  input  logic [BLOCKLOCK_W-1:0] in_blocklock_local,
  input  logic                   sync_pushed,
  input  logic                   data_pushed,
  output logic                   sync_pending
);
  localparam int unsigned CNT_W = $clog2(SYNC_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYNC_PERIOD);

  logic [CNT_W-1:0]       data_cnt;
  logic [CNT_W-1:0]       data_cnt_next;
  logic [BLOCKLOCK_W-1:0] blocklock_sent;
  logic [BLOCKLOCK_W-1:0] blocklock_sent_next;
  logic                   sync_pending_next;

  always_comb begin
    data_cnt_next       = data_cnt;
    blocklock_sent_next = blocklock_sent;
    if (sync_pushed) begin
      data_cnt_next       = '0;
      blocklock_sent_next = in_blocklock_local;
    end else if (data_pushed && (data_cnt != CNT_MAX)) begin
      data_cnt_next = data_cnt + 1'b1;
    end
    // Comparing against the post-update value re-arms a sync if lock moves right after one.
    sync_pending_next = (data_cnt_next == CNT_MAX)
                      | (in_blocklock_local != blocklock_sent_next)
                      | (sync_pending & ~sync_pushed);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_cnt       <= '0;
      blocklock_sent <= '0;
      sync_pending   <= 1'b1;
    end else if (in_enable) begin
      data_cnt       <= data_cnt_next;
      blocklock_sent <= blocklock_sent_next;
      sync_pending   <= sync_pending_next;
    end
  end
endmodule

// File: rtl/tx_sync_insert_stage.sv
// Tags payload words with a sync flag and interleaves blocklock sync words into the TX FIFO.
// Sync words always win over data; the source is stalled while one is pending.
module tx_sync_insert_stage
  import tx_sync_insert_stage_pkg::*;
#(
  parameter int unsigned WR_WIDTH    = WR_WIDTH_DEFAULT,
  parameter int unsigned SYNC_PERIOD = SYNC_PERIOD_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_enable,
  input  logic [BLOCKLOCK_W-1:0] in_blocklock_local,
  input  logic                   data_valid_src,
  input  logic [WR_WIDTH-2:0]    data_src,
  output logic                   canpush_src,
  input  logic                   canpush_fifo,
  output logic                   push_fifo,
  output logic [WR_WIDTH-1:0]    data_fifo,
  output logic                   out_sync_sent
);
  logic                sync_pending;
  push_kind_e          push_kind;
  logic [WR_WIDTH-1:0] sync_word;

  assign canpush_src = in_enable & canpush_fifo & ~sync_pending;

  always_comb begin
    push_kind = PUSH_NONE;
    if (in_enable) begin
      if (sync_pending && canpush_fifo) begin
        push_kind = PUSH_SYNC;
      end else if (data_valid_src && canpush_src) begin
        push_kind = PUSH_DATA;
      end
    end
  end

  always_comb begin
    sync_word                              = '0;
    sync_word[WR_WIDTH-1]                  = 1'b1;
    sync_word[BLOCKLOCK_MSB:BLOCKLOCK_LSB] = in_blocklock_local;
  end

  // Strobes clear whenever nothing is pushed, including in_enable=0, so a word is never written twice.
  always_ff @(posedge clock) begin
    if (reset) begin
      push_fifo     <= 1'b0;
      data_fifo     <= '0;
      out_sync_sent <= 1'b0;
    end else begin
      push_fifo     <= 1'b0;
      out_sync_sent <= 1'b0;
      case (push_kind)
        PUSH_SYNC: begin
          push_fifo     <= 1'b1;
          data_fifo     <= sync_word;
          out_sync_sent <= 1'b1;
        end
        PUSH_DATA: begin
          push_fifo <= 1'b1;
          data_fifo <= {1'b0, data_src};
        end
        default: ;
      endcase
    end
  end

  tx_sync_scheduler #(
    .SYNC_PERIOD(SYNC_PERIOD)
  ) u_scheduler (
    .clock              (clock),
    .reset              (reset),
    .in_enable          (in_enable),
    .in_blocklock_local (in_blocklock_local),
    .sync_pushed        (push_kind == PUSH_SYNC),
    .data_pushed        (push_kind == PUSH_DATA),
    .sync_pending       (sync_pending)
  );
endmodule

// File: tb/tb_tx_sync_insert_stage.sv
// Directed bench for tx_sync_insert_stage with SYNC_PERIOD=4; pushed words are collected and
// compared against hand-built expected sequences.
module tb_tx_sync_insert_stage;
  localparam int unsigned WR_WIDTH    = 48;
  localparam int unsigned SYNC_PERIOD = 4;
  localparam logic [WR_WIDTH-2:0] BASE = 47'h1000_0000_0100;

  logic                clock;
  logic                reset;
  logic                in_enable;
  logic [3:0]          in_blocklock_local;
  logic                data_valid_src;
  logic [WR_WIDTH-2:0] data_src;
  logic                canpush_src;
  logic                canpush_fifo;
  logic                push_fifo;
  logic [WR_WIDTH-1:0] data_fifo;
  logic                out_sync_sent;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Each captured entry is {out_sync_sent, data_fifo}.
  logic [WR_WIDTH:0] got[$];
  logic [WR_WIDTH:0] exp_q[$];
  logic              no_dup_mode = 1'b0;
  logic              prev_push   = 1'b0;

  tx_sync_insert_stage #(
    .WR_WIDTH    (WR_WIDTH),
    .SYNC_PERIOD (SYNC_PERIOD)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .in_enable          (in_enable),
    .in_blocklock_local (in_blocklock_local),
    .data_valid_src     (data_valid_src),
    .data_src           (data_src),
    .canpush_src        (canpush_src),
    .canpush_fifo       (canpush_fifo),
    .push_fifo          (push_fifo),
    .data_fifo          (data_fifo),
    .out_sync_sent      (out_sync_sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [WR_WIDTH:0] sw(input logic [3:0] bl);
    sw = {2'b11, 43'd0, bl};
  endfunction

  function automatic logic [WR_WIDTH:0] dw(input int n);
    dw = {2'b00, BASE + 47'(n)};
  endfunction

  always @(posedge clock) begin
    #1;
    if (!reset) begin
      if (push_fifo) got.push_back({out_sync_sent, data_fifo});
      else if (out_sync_sent) check("sync_sent_without_push", out_sync_sent, 0);
      if (no_dup_mode && push_fifo) check("no_dup_push", prev_push, 0);
      prev_push = push_fifo;
    end else begin
      prev_push = 1'b0;
    end
  end

  // Entered at a negedge; advances the source word when the previous cycle accepted it.
  task automatic run_cycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      #1;
      acc = canpush_src && data_valid_src;
      @(posedge clock);
      @(negedge clock);
      if (acc) data_src = data_src + 1'b1;
    end
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    in_enable          = 1'b1;
    canpush_fifo       = 1'b1;
    data_valid_src     = 1'b0;
    in_blocklock_local = 4'h0;
    run_cycles(2);
    reset    = 1'b0;
    data_src = BASE;
    got.delete();
    exp_q.delete();
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic build_periodic(input int n);
    int d = 0;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      if (k % 5 == 0) exp_q.push_back(sw(4'h0));
      else begin
        exp_q.push_back(dw(d));
        d++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_enable = 1'b1; canpush_fifo = 1'b1; data_valid_src = 1'b0;
    in_blocklock_local = 4'h0; data_src = BASE;
    @(negedge clock);

    // 1: reset state and first sync word
    do_reset();
    check("rst_push_fifo", push_fifo, 0);
    check("rst_data_fifo", data_fifo, 0);
    check("rst_sync_sent", out_sync_sent, 0);
    #1;
    check("rst_canpush_src", canpush_src, 0);
    run_cycles(1);
    check("first_push", push_fifo, 1);
    check("first_word", data_fifo, 48'h8000_0000_0000);
    check("first_sync_sent", out_sync_sent, 1);
    check("canpush_after_sync", canpush_src, 1);

    // 2: periodic sync with continuous data
    do_reset();
    data_valid_src = 1'b1;
    run_cycles(16);
    build_periodic(16);
    check_seq("periodic");

    // 3: blocklock change mid-stream
    do_reset();
    data_valid_src = 1'b1;
    run_cycles(3);
    in_blocklock_local = 4'hF;
    run_cycles(7);
    exp_q = '{sw(4'h0), dw(0), dw(1), dw(2), sw(4'hF), dw(3), dw(4), dw(5), dw(6), sw(4'hF)};
    check_seq("lock_change");
    check("lock_sync_word", 64'(got.size() > 4 ? got[4][WR_WIDTH-1:0] : '0), 48'h8000_0000_000F);

    // 4: FIFO backpressure with a pending sync and valid data
    do_reset();
    data_valid_src = 1'b1;
    run_cycles(2);
    canpush_fifo       = 1'b0;
    in_blocklock_local = 4'hF;
    run_cycles(10);
    check("stall_no_push", 64'(got.size()), 2);
    canpush_fifo = 1'b1;
    run_cycles(3);
    exp_q = '{sw(4'h0), dw(0), sw(4'hF), dw(1), dw(2)};
    check_seq("backpressure");

    // 5: in_enable toggling reproduces the periodic sequence without duplicates
    do_reset();
    data_valid_src = 1'b1;
    no_dup_mode    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_enable = 1'b1;
      run_cycles(1);
      in_enable = 1'b0;
      run_cycles(1);
    end
    no_dup_mode = 1'b0;
    in_enable   = 1'b1;
    build_periodic(16);
    check_seq("enable_toggle");

    // 6: reset with a push in flight
    do_reset();
    data_valid_src = 1'b1;
    run_cycles(3);
    check("pre_reset_push", push_fifo, 1);
    reset          = 1'b1;
    data_valid_src = 1'b0;
    run_cycles(1);
    check("reset_cancels_push", push_fifo, 0);
    reset = 1'b0;
    got.delete();
    data_valid_src = 1'b1;
    run_cycles(2);
    exp_q = '{sw(4'h0), dw(2)};
    check_seq("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
